// File: rtl/pulse_stretch_pkg.sv
// Shared types and game-level defaults for ms-timed pulse stretching.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        COOLDOWN = 2'd2
    } ps_state_e;

    localparam int PS_HOLD_MS_DEF = 100;
    localparam int PS_GAP_MS_DEF  = 0;

endpackage

// File: rtl/tick_sync.sv
// Brings the free-running 1 kHz square wave into the clk domain
// and emits a registered one-cycle tick per rising edge.
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_1ms,
    output logic tick
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            tick <= 1'b0;
        end else begin
            s1   <= clk_1ms;
            s2   <= s1;
            s3   <= s2;
            tick <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/pulse_stretch.sv
// Stretches a one-cycle load pulse into a level held for HOLD_MS
// ticks, with optional retrigger and a post-hold cooldown.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HOLD_MS   = PS_HOLD_MS_DEF,
    parameter int GAP_MS    = PS_GAP_MS_DEF,
    parameter int RETRIGGER = 1,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_1ms,
    input  logic load_in,
    output logic level_out,
    output logic busy,
    output logic done,
    output logic dropped
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_MS);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_MS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam bit               RETRIG  = (RETRIGGER != 0);
    localparam bit               HAS_GAP = (GAP_MS > 0);

    ps_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             tick;

    tick_sync u_tick_sync (
        .clk     (clk),
        .rst     (rst),
        .clk_1ms (clk_1ms),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            done    <= 1'b0;
            dropped <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_in) begin
                        state     <= HOLD;
                        cnt       <= HOLD_LD;
                        level_out <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                HOLD: begin
                    // a reload beats a coincident final tick
                    if (load_in && RETRIG) begin
                        cnt <= HOLD_LD;
                    end else begin
                        if (load_in) begin
                            dropped <= 1'b1;
                        end
                        if (tick) begin
                            if (cnt == ONE) begin
                                level_out <= 1'b0;
                                done      <= 1'b1;
                                if (HAS_GAP) begin
                                    state <= COOLDOWN;
                                    cnt   <= GAP_LD;
                                end else begin
                                    state <= IDLE;
                                    cnt   <= '0;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                cnt <= cnt - ONE;
                            end
                        end
                    end
                end
                COOLDOWN: begin
                    if (load_in) begin
                        dropped <= 1'b1;
                    end
                    if (tick) begin
                        if (cnt == ONE) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    level_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench: three builds (retrigger, no retrigger, no gap)
// share one clock and a 20-cycle clk_1ms.
module tb_pulse_stretch;

    logic clk = 1'b0;
    logic rst;
    logic clk_1ms;
    logic la, lb, lc;
    logic a_lvl, a_busy, a_done, a_drop;
    logic b_lvl, b_busy, b_done, b_drop;
    logic c_lvl, c_busy, c_done, c_drop;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit a_rst_done_seen = 1'b0;
    bit a_rtg_done_seen = 1'b0;

    always #5 clk = ~clk;

    pulse_stretch #(.HOLD_MS(3), .GAP_MS(2), .RETRIGGER(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .clk_1ms(clk_1ms), .load_in(la),
        .level_out(a_lvl), .busy(a_busy), .done(a_done), .dropped(a_drop)
    );

    pulse_stretch #(.HOLD_MS(3), .GAP_MS(2), .RETRIGGER(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .clk_1ms(clk_1ms), .load_in(lb),
        .level_out(b_lvl), .busy(b_busy), .done(b_done), .dropped(b_drop)
    );

    pulse_stretch #(.HOLD_MS(3), .GAP_MS(0), .RETRIGGER(1), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .clk_1ms(clk_1ms), .load_in(lc),
        .level_out(c_lvl), .busy(c_busy), .done(c_done), .dropped(c_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    // rising clk_1ms at cyc%20==10; tick acted on at the edge into cyc%20==14
    initial begin
        logic [3:0] ao, bo, co;
        rst = 1'b1;
        clk_1ms = 1'b0;
        la = 1'b0;
        lb = 1'b0;
        lc = 1'b0;
        for (int n = 1; n <= 520; n++) begin
            @(posedge clk);
            #1;
            cyc = n;
            ao = {a_lvl, a_busy, a_done, a_drop};
            bo = {b_lvl, b_busy, b_done, b_drop};
            co = {c_lvl, c_busy, c_done, c_drop};
            if (cyc >= 46 && cyc < 100 && a_done) a_rst_done_seen = 1'b1;
            if (cyc >= 221 && cyc < 374 && a_done) a_rtg_done_seen = 1'b1;
            case (cyc)
                5: begin
                    chk("rst_a", 32'(ao), 32'h0);
                    chk("rst_b", 32'(bo), 32'h0);
                    chk("rst_c", 32'(co), 32'h0);
                end
                39:  chk("idle_ticks_a", 32'(ao), 32'h0);
                41:  chk("a_load_pre_rst", 32'(ao), 32'hC);
                46:  chk("a_rst_abort", 32'(ao), 32'h0);
                100: chk("a_no_done_after_rst", 32'(a_rst_done_seen), 32'h0);
                101: begin
                    chk("a_rise", 32'(ao), 32'hC);
                    chk("b_rise", 32'(bo), 32'hC);
                    chk("c_rise", 32'(co), 32'hC);
                end
                121: chk("b_drop_hold", 32'(bo), 32'hD);
                122: chk("b_drop_1cyc", 32'(bo), 32'hC);
                153: begin
                    chk("a_hold_last", 32'(ao), 32'hC);
                    chk("c_busy_last", 32'(co), 32'hC);
                end
                154: begin
                    chk("a_hold_end", 32'(ao), 32'h6);
                    chk("b_done_and_drop", 32'(bo), 32'h7);
                    chk("c_done_busy_fall", 32'(co), 32'h2);
                end
                155: begin
                    chk("a_cool", 32'(ao), 32'h4);
                    chk("b_cool", 32'(bo), 32'h4);
                    chk("c_reload_no_drop", 32'(co), 32'hC);
                end
                193: chk("a_cool_last", 32'(ao), 32'h4);
                194: begin
                    chk("a_idle", 32'(ao), 32'h0);
                    chk("b_idle", 32'(bo), 32'h0);
                end
                214: chk("c_second_end", 32'(co), 32'h2);
                274: chk("a_rtg_early", 32'(ao), 32'hC);
                314: chk("a_rtg_on_tick", 32'(ao), 32'hC);
                354: chk("a_rtg_mid", 32'(ao), 32'hC);
                373: chk("a_rtg_last", 32'(ao), 32'hC);
                374: begin
                    chk("a_rtg_no_done", 32'(a_rtg_done_seen), 32'h0);
                    chk("a_rtg_end", 32'(ao), 32'h6);
                end
                381: chk("a_cool_drop", 32'(ao), 32'h5);
                382: chk("a_cool_drop_1cyc", 32'(ao), 32'h4);
                414: chk("a_final_tick_drop", 32'(ao), 32'h1);
                415: chk("a_new_hold", 32'(ao), 32'hC);
                474: chk("a_new_hold_end", 32'(ao), 32'h6);
                514: chk("a_new_idle", 32'(ao), 32'h0);
                default: ;
            endcase
            rst = (cyc < 5) || (cyc == 45);
            clk_1ms = ((cyc % 20) >= 10);
            la = (cyc == 40) || (cyc == 100) || (cyc == 220)
              || (cyc == 272) || (cyc == 313) || (cyc == 380)
              || (cyc == 413) || (cyc == 414);
            lb = (cyc == 100) || (cyc == 120) || (cyc == 153);
            lc = (cyc == 100) || (cyc == 154);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Converts a single-cycle load pulse (one `clk` wide, from the button edge generator) back into a level held for a programmed number of milliseconds.
- Timing comes from the `clk_1ms` tick.
- Drives visible or audible game outputs (LED flash, buzzer) in the ping-pong design.
- Supports retrigger and a post-hold cooldown during which new pulses are dropped and flagged.

Parameters:
- HOLD_MS, 100, hold length in `clk_1ms` ticks; must be >= 1.
- GAP_MS, 0, cooldown length in ticks after hold ends; 0 = no cooldown.
- RETRIGGER, 1, 1 = load during HOLD reloads the hold counter; 0 = load during HOLD is dropped.
- CNT_W, 16, counter width; must hold max(HOLD_MS, GAP_MS).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- clk_1ms  input  1  1 kHz square wave, not related to `clk`; sampled, never used as a clock.
- load_in  input  1  single-cycle request pulse, `clk` domain.
- level_out  output  1  stretched level; registered.
- busy  output  1  high in HOLD or COOLDOWN; registered.
- done  output  1  one-cycle pulse when HOLD ends.
- dropped  output  1  one-cycle pulse when `load_in` is ignored.

Behaviour:
- Tick generation:
  - `clk_1ms` passes through a 2-FF synchronizer, then a rising-edge detect.
  - tick = 1 for one `clk` cycle, 3 `clk` cycles after the `clk_1ms` rising edge.
- States: IDLE, HOLD, COOLDOWN.
- Reset:
  - state = IDLE, counter = 0, sync FFs = 0.
  - level_out, busy, done, dropped all 0.
  - Reset mid-HOLD or mid-COOLDOWN aborts immediately with no `done` pulse.
- IDLE:
  - `load_in` at cycle t gives HOLD, counter = HOLD_MS, level_out = busy = 1 at t+1.
  - A tick in the same cycle is ignored.
- HOLD:
  - Each tick decrements the counter.
  - Tick with counter == 1 ends the hold. Next cycle: level_out = 0, done = 1 for one cycle.
  - Next state is COOLDOWN with counter = GAP_MS if GAP_MS > 0; otherwise IDLE with busy = 0.
  - Hold duration is between HOLD_MS-1 and HOLD_MS ms, because the first tick may arrive early. This is accepted.
- Load during HOLD:
  - RETRIGGER = 1: counter reloads to HOLD_MS. If a tick coincides, the reload wins and the hold does not end, even if counter == 1.
  - RETRIGGER = 0: dropped = 1 next cycle, no state change.
- COOLDOWN:
  - level_out = 0, busy = 1.
  - Each tick decrements the counter; tick with counter == 1 gives IDLE, busy = 0 next cycle.
  - `load_in` in COOLDOWN: dropped = 1, ignored. This includes the cycle of the final tick.
- `load_in` in the same cycle the FSM returns to IDLE (the state register still reads COOLDOWN or HOLD): treated per the current state, never lost silently. It produces either a dropped pulse or a retrigger.
- `load_in` held high for several cycles: each cycle is treated as a separate pulse. In IDLE, only the first starts HOLD; the rest follow the HOLD rules.
- Counter arithmetic: unsigned CNT_W bits, never decremented below 1 within a state. Wrap-around is unreachable.
- `done` and `dropped` are never high for more than one consecutive cycle per event. Both can be high in the same cycle only if RETRIGGER = 0 and a load coincides with the end of hold.

Decomposition:
- Shared package/header: state encodings (IDLE = 2'd0, HOLD = 2'd1, COOLDOWN = 2'd2) and the default HOLD_MS/GAP_MS constants used by the game top level.
- One sub-module: `tick_sync` (2-FF synchronizer plus rising-edge detect of `clk_1ms`, synchronous reset, output `tick`). It is reusable by other ms-timed blocks.
- FSM and counter stay in `pulse_stretch`.

Test Plan (bench uses HOLD_MS=3, GAP_MS=2; `clk_1ms` modelled with a 20-`clk` period):
- rst high 5 cycles, then toggle `clk_1ms` with no load: level_out, busy, done, dropped stay 0. Assert rst during HOLD: all outputs are 0 the next cycle and no done pulse follows.
- Single `load_in` pulse at cycle 100:
  - level_out = 1 at cycle 101.
  - level_out falls 1 cycle after the 3rd tick; done = 1 for exactly that cycle.
  - busy falls 1 cycle after the 2nd tick following.
- RETRIGGER=1, second load 1 cycle before the 3rd tick, and a load coincident with a tick at counter == 1: level_out stays 1 for 3 further ticks after each reload; no done pulse in between.
- RETRIGGER=0, load during HOLD: dropped = 1 for one cycle; hold still ends after the original 3 ticks.
- Load during COOLDOWN and on its final tick cycle: dropped = 1 each time; level_out stays 0. A load 1 cycle after busy falls starts a new HOLD.
- GAP_MS=0 build: done and busy fall in the same cycle. A load on the following cycle starts HOLD with no dropped pulse.
